// File: rtl/hyperbus_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_rsp_pkg
// Description : Shared types, CA/CR0 field positions and decode helpers for
//               the HyperBus memory-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
package hyperbus_rsp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CA    = 3'd1,
      ST_LAT   = 3'd2,
      ST_WR    = 3'd3,
      ST_RD    = 3'd4,
      ST_REGWR = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam int CA_RD_BIT  = 47;
   localparam int CA_REG_BIT = 46;
   localparam int CA_LIN_BIT = 45;

   localparam int          CR0_LAT_LSB     = 4;
   localparam int          CR0_FIXED_BIT   = 3;
   localparam int          CR0_BL_LSB      = 0;
   localparam logic [15:0] CR0_RST_DEFAULT = 16'h8F1F;

   function automatic logic [3:0] lat_decode(input logic [3:0] code);
      case (code)
         4'b0000: return 4'd5;
         4'b0001: return 4'd6;
         4'b0010: return 4'd7;
         4'b1110: return 4'd3;
         4'b1111: return 4'd4;
         default: return 4'd6;
      endcase
   endfunction

   // Returns (wrap length - 1), i.e. the mask of the address bits that wrap.
   function automatic logic [5:0] wrap_mask(input logic [1:0] bl);
      case (bl)
         2'b00:   return 6'd63;
         2'b01:   return 6'd31;
         2'b10:   return 6'd7;
         default: return 6'd15;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/hyperbus_rsp_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_rsp_mem_if
// Description : Parallel-side HyperBus link between controller PHY and the
//               memory responder (one 16-bit word per clock).
// Revision    : 1.0 - initial release
// ============================================================================
interface hyperbus_rsp_mem_if;
   logic        cs_ni;
   logic [15:0] dq_i;
   logic [1:0]  rwds_i;
   logic [15:0] dq_o;
   logic        dq_oe_o;
   logic [1:0]  rwds_o;
   logic        rwds_oe_o;
   logic [2:0]  state_o;

   modport slave (
      input  cs_ni, dq_i, rwds_i,
      output dq_o, dq_oe_o, rwds_o, rwds_oe_o, state_o
   );

   modport master (
      output cs_ni, dq_i, rwds_i,
      input  dq_o, dq_oe_o, rwds_o, rwds_oe_o, state_o
   );
endinterface
`default_nettype wire

// File: rtl/hyperbus_rsp_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_rsp_burst_addr
// Description : Burst word-address counter; linear or aligned-wrap stepping.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_rsp_burst_addr #(
   parameter int ADDR_W = 12
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              load,
   input  wire logic [ADDR_W-1:0] load_addr,
   input  wire logic              load_linear,
   input  wire logic [5:0]        load_mask,
   input  wire logic              step,
   output logic      [ADDR_W-1:0] addr
);

   logic              linear_q;
   logic [ADDR_W-1:0] mask_q;
   logic [ADDR_W-1:0] inc;

   assign inc = addr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         linear_q <= 1'b1;
         mask_q   <= '0;
      end else if (load) begin
         addr     <= load_addr;
         linear_q <= load_linear;
         mask_q   <= ADDR_W'(load_mask);
      end else if (step) begin
         // Wrapped mode keeps the group base and lets only the low bits roll.
         addr <= linear_q ? inc : ((addr & ~mask_q) | (inc & mask_q));
      end
   end

endmodule
`default_nettype wire

// File: rtl/hyperbus_rsp_mem.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_rsp_mem
// Description : HyperBus device-side responder with word array and CR0.
//               Optional abort counter: define HYPERBUS_RSP_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_rsp_mem
   import hyperbus_rsp_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter int          ADDR_W    = $clog2(MEM_WORDS),
   parameter logic [15:0] CR0_RST   = CR0_RST_DEFAULT
) (
   input  wire logic         clk_sys_i,
   input  wire logic         rst_i,
   hyperbus_rsp_mem_if.slave bus
`ifdef HYPERBUS_RSP_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt_o
`endif
);

   state_t            state_q, state_d;
   logic [1:0]        ca_cnt;
   logic [15:0]       ca_w0, ca_w1;
   logic [47:0]       ca_full;
   logic [31:0]       ca_word_addr;
   logic              ca_last;
   logic              is_read, is_reg;
   logic [3:0]        lat_base;
   logic [4:0]        lat_total, lat_cnt;
   logic [15:0]       cr0, rd_word;
   logic [ADDR_W-1:0] addr;
   logic              addr_step;
   logic [15:0]       mem [MEM_WORDS];

   assign ca_full      = {ca_w0, ca_w1, bus.dq_i};
   assign ca_word_addr = {ca_full[44:16], ca_full[2:0]};
   assign ca_last      = (state_q == ST_CA) && (ca_cnt == 2'd2) && !bus.cs_ni;
   assign lat_base     = lat_decode(cr0[CR0_LAT_LSB +: 4]);
   assign lat_total    = cr0[CR0_FIXED_BIT] ? {lat_base, 1'b0} : {1'b0, lat_base};
   assign addr_step    = (state_d == ST_RD) || ((state_q == ST_WR) && !bus.cs_ni);
   assign bus.state_o  = state_q;

   always_comb begin
      state_d = state_q;
      if (bus.cs_ni) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_CA;
            ST_CA: begin
               if (ca_cnt == 2'd2) begin
                  state_d = (!ca_full[CA_RD_BIT] && ca_full[CA_REG_BIT]) ? ST_REGWR : ST_LAT;
               end
            end
            ST_LAT: begin
               if (lat_cnt == 5'd0) state_d = is_read ? ST_RD : ST_WR;
            end
            ST_WR:    state_d = ST_WR;
            ST_RD:    state_d = ST_RD;
            ST_REGWR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_word = mem[addr];
      if (is_reg) rd_word = addr[0] ? 16'h0000 : cr0;
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ca_cnt  <= 2'd0;
         ca_w0   <= 16'h0000;
         ca_w1   <= 16'h0000;
         is_read <= 1'b0;
         is_reg  <= 1'b0;
         lat_cnt <= 5'd0;
         cr0     <= CR0_RST;
      end else begin
         state_q <= state_d;
         ca_cnt  <= ((state_q == ST_CA) && !bus.cs_ni) ? ca_cnt + 2'd1 : 2'd0;
         if ((state_q == ST_CA) && (ca_cnt == 2'd0)) ca_w0 <= bus.dq_i;
         if ((state_q == ST_CA) && (ca_cnt == 2'd1)) ca_w1 <= bus.dq_i;
         // The 3rd CA cycle itself counts as the first latency cycle.
         if (ca_last) begin
            is_read <= ca_full[CA_RD_BIT];
            is_reg  <= ca_full[CA_REG_BIT];
            lat_cnt <= lat_total - 5'd2;
         end else if ((state_q == ST_LAT) && (lat_cnt != 5'd0)) begin
            lat_cnt <= lat_cnt - 5'd1;
         end
         if ((state_q == ST_REGWR) && !bus.cs_ni && !addr[0]) cr0 <= bus.dq_i;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         bus.dq_o      <= 16'h0000;
         bus.dq_oe_o   <= 1'b0;
         bus.rwds_o    <= 2'b00;
         bus.rwds_oe_o <= 1'b0;
      end else begin
         bus.dq_o      <= (state_d == ST_RD) ? rd_word : 16'h0000;
         bus.dq_oe_o   <= (state_d == ST_RD);
         bus.rwds_oe_o <= (state_d == ST_RD) || (state_d == ST_CA);
         if (state_d == ST_CA)      bus.rwds_o <= {2{cr0[CR0_FIXED_BIT]}};
         else if (state_d == ST_RD) bus.rwds_o <= 2'b10;
         else                       bus.rwds_o <= 2'b00;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (!rst_i && (state_q == ST_WR) && !bus.cs_ni) begin
         if (!bus.rwds_i[1]) mem[addr][15:8] <= bus.dq_i[15:8];
         if (!bus.rwds_i[0]) mem[addr][7:0]  <= bus.dq_i[7:0];
      end
   end

   hyperbus_rsp_burst_addr #(
      .ADDR_W (ADDR_W)
   ) u_burst_addr (
      .clk         (clk_sys_i),
      .rst         (rst_i),
      .load        (ca_last),
      .load_addr   (ca_word_addr[ADDR_W-1:0]),
      .load_linear (ca_full[CA_LIN_BIT]),
      .load_mask   (wrap_mask(cr0[CR0_BL_LSB +: 2])),
      .step        (addr_step),
      .addr        (addr)
   );

`ifdef HYPERBUS_RSP_ERR_CNT_EN
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         err_cnt_o <= 8'd0;
      end else if (((state_q == ST_CA) || (state_q == ST_LAT)) && bus.cs_ni &&
                   (err_cnt_o != 8'hFF)) begin
         err_cnt_o <= err_cnt_o + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_rsp_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperbus_rsp_mem
// Description : Directed scoreboard bench for the HyperBus memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperbus_rsp_mem;
   import hyperbus_rsp_pkg::*;

   localparam int MEM_WORDS = 4096;

   logic clk = 1'b0;
   logic rst;
   hyperbus_rsp_mem_if bus ();
`ifdef HYPERBUS_RSP_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int          passed = 0;
   int          failed = 0;
   int          total  = 0;
   logic [15:0] model [int];
   logic [15:0] cr0_m;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   hyperbus_rsp_mem #(
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk_sys_i (clk),
      .rst_i     (rst),
      .bus       (bus)
`ifdef HYPERBUS_RSP_ERR_CNT_EN
      ,
      .err_cnt_o (err_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int lat_m(input logic [15:0] c);
      int l;
      case (c[7:4])
         4'd0:    l = 5;
         4'd1:    l = 6;
         4'd2:    l = 7;
         4'd14:   l = 3;
         4'd15:   l = 4;
         default: l = 6;
      endcase
      return c[3] ? 2 * l : l;
   endfunction

   function automatic int next_m(input int a, input bit lin, input logic [15:0] c);
      int n;
      case (c[1:0])
         2'd0:    n = 64;
         2'd1:    n = 32;
         2'd2:    n = 8;
         default: n = 16;
      endcase
      if (lin) return (a + 1) % MEM_WORDS;
      return (a / n) * n + ((a + 1) % n);
   endfunction

   task automatic send_ca(input bit rd, input bit rg, input bit lin, input int addr);
      logic [47:0] ca;
      logic [31:0] wa;
      wa        = addr;
      ca        = '0;
      ca[47]    = rd;
      ca[46]    = rg;
      ca[45]    = lin;
      ca[44:16] = wa[31:3];
      ca[2:0]   = wa[2:0];
      bus.cs_ni = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.dq_i = ca[47-16*i -: 16];
         check("ca_rwds_oe", {15'd0, bus.rwds_oe_o}, 16'd1);
         check("ca_rwds", {14'd0, bus.rwds_o}, {14'd0, {2{cr0_m[3]}}});
         tick();
      end
      bus.dq_i = 16'h0000;
   endtask

   task automatic write_burst(input int addr, input bit lin, input int n, input logic [15:0] d0,
                              input logic [15:0] dstep, input logic [1:0] mask, input int rst_word);
      int          a;
      logic [15:0] d, old;
      send_ca(1'b0, 1'b0, lin, addr);
      repeat (lat_m(cr0_m) - 1) tick();
      check("wr_first_state", 16'(bus.state_o), 16'(ST_WR));
      a = addr;
      d = d0;
      for (int k = 0; k < n; k++) begin
         bus.dq_i   = d;
         bus.rwds_i = mask;
         if (k == rst_word) begin
            rst = 1'b1;
         end else begin
            old = model.exists(a) ? model[a] : 16'hxxxx;
            if (!mask[1]) old[15:8] = d[15:8];
            if (!mask[0]) old[7:0]  = d[7:0];
            model[a] = old;
         end
         tick();
         if (k == rst_word) break;
         a = next_m(a, lin, cr0_m);
         d = d + dstep;
      end
      bus.rwds_i = 2'b00;
      bus.cs_ni  = 1'b1;
      if (rst_word >= 0) begin
         check("rst_state", 16'(bus.state_o), 16'(ST_IDLE));
         check("rst_dq_oe", {15'd0, bus.dq_oe_o}, 16'd0);
         rst   = 1'b0;
         cr0_m = 16'h8F1F;
      end
      tick();
      check("wr_end_state", 16'(bus.state_o), 16'(ST_IDLE));
   endtask

   task automatic read_burst(input int addr, input bit lin, input bit rg, input int n);
      int a;
      int l;
      a = addr;
      l = lat_m(cr0_m);
      send_ca(1'b1, rg, lin, addr);
      for (int k = 0; k < n; k++) begin
         if (rg) exp_q.push_back(a[0] ? 16'h0000 : cr0_m);
         else    exp_q.push_back(model[a]);
         a = next_m(a, lin, cr0_m);
      end
      repeat (l - 2) tick();
      check("rd_early_oe", {15'd0, bus.dq_oe_o}, 16'd0);
      tick();
      for (int k = 0; k < n; k++) begin
         check("rd_oe", {15'd0, bus.dq_oe_o}, 16'd1);
         if (k == 0) check("rd_rwds", {14'd0, bus.rwds_o}, 16'd2);
         if (bus.dq_oe_o && (exp_q.size() > 0)) check("rd_data", bus.dq_o, exp_q.pop_front());
         if (k == n - 1) bus.cs_ni = 1'b1;
         tick();
      end
      check("rd_oe_off", {15'd0, bus.dq_oe_o}, 16'd0);
      check("rd_q_empty", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   task automatic reg_write(input logic [15:0] val);
      send_ca(1'b0, 1'b1, 1'b1, 0);
      check("regwr_state", 16'(bus.state_o), 16'(ST_REGWR));
      bus.dq_i = val;
      tick();
      check("regwr_done", 16'(bus.state_o), 16'(ST_DONE));
      bus.dq_i = 16'hFFFF;
      tick();
      check("regwr_hold", 16'(bus.state_o), 16'(ST_DONE));
      bus.cs_ni = 1'b1;
      bus.dq_i  = 16'h0000;
      tick();
      check("regwr_idle", 16'(bus.state_o), 16'(ST_IDLE));
      cr0_m = val;
   endtask

   initial begin
      #500000;
      $error("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      bus.cs_ni  = 1'b1;
      bus.dq_i   = 16'h0000;
      bus.rwds_i = 2'b00;
      cr0_m      = 16'h8F1F;
      repeat (3) tick();
      check("rst_state_o", 16'(bus.state_o), 16'(ST_IDLE));
      check("rst_dq_o", bus.dq_o, 16'h0000);
      check("rst_dq_oe_o", {15'd0, bus.dq_oe_o}, 16'd0);
      check("rst_rwds_o", {14'd0, bus.rwds_o}, 16'd0);
      check("rst_rwds_oe_o", {15'd0, bus.rwds_oe_o}, 16'd0);
`ifdef HYPERBUS_RSP_ERR_CNT_EN
      check("rst_err_cnt", {8'd0, err_cnt}, 16'd0);
`endif
      rst = 1'b0;
      tick();

      write_burst(16'h10, 1'b1, 4, 16'h1111, 16'h1111, 2'b00, -1);
      read_burst(16'h10, 1'b1, 1'b0, 4);
      read_burst(0, 1'b1, 1'b1, 2);

      // Latency code 0000 (L=5, doubled), 32-word wrap.
      reg_write(16'h8E09);
      write_burst(16'h1E, 1'b0, 4, 16'hA01E, 16'h0001, 2'b00, -1);
      read_burst(16'h1E, 1'b0, 1'b0, 4);

      write_burst(16'h10, 1'b1, 1, 16'hABCD, 16'h0000, 2'b01, -1);
      read_burst(16'h10, 1'b1, 1'b0, 1);

      // Write command to 0x11 abandoned in its 2nd CA word.
      bus.cs_ni = 1'b0;
      tick();
      bus.dq_i = 16'h2000;
      tick();
      bus.cs_ni = 1'b1;
      bus.dq_i  = 16'h0000;
      tick();
      check("abort_state", 16'(bus.state_o), 16'(ST_IDLE));
      check("abort_rwds_oe", {15'd0, bus.rwds_oe_o}, 16'd0);
`ifdef HYPERBUS_RSP_ERR_CNT_EN
      check("abort_err_cnt", {8'd0, err_cnt}, 16'd1);
`endif
      bus.dq_i = 16'hDEAD;
      repeat (4) tick();
      bus.dq_i = 16'h0000;
      read_burst(16'h10, 1'b1, 1'b0, 4);

      write_burst(16'h40, 1'b1, 3, 16'h0A0A, 16'h0101, 2'b00, -1);
      write_burst(16'h40, 1'b1, 3, 16'h5000, 16'h0001, 2'b00, 2);
      read_burst(0, 1'b1, 1'b1, 1);
      read_burst(16'h40, 1'b1, 1'b0, 3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
